// File: rtl/test_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : test_seq_ctrl
// Brief    : MAC loopback test sequencer (arm checker, fire generator, judge).
// Revision : 1.0 - initial release
// ============================================================================
module test_seq_ctrl #(
    parameter int G_CNT_W       = 16,
    parameter int G_TIMEOUT     = 4096,
    parameter int G_GAP         = 12,
    parameter int G_STOP_ON_ERR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [G_CNT_W-1:0] cfg_nframes,
    input  logic               test_start,
    input  logic               test_stop,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               rx_start,
    input  logic               rx_frame_ok,
    input  logic               rx_err,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [G_CNT_W-1:0] frame_cnt,
    output logic [G_CNT_W-1:0] err_cnt
);

    // One down-counter serves both the frame timeout and the inter-frame gap.
    localparam int                 c_tmr_w    = $clog2(G_TIMEOUT + G_GAP + 2);
    localparam logic [c_tmr_w-1:0] c_tmo_load = c_tmr_w'(G_TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_gap_load = (G_GAP > 0) ? c_tmr_w'(G_GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_GAP    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [G_CNT_W-1:0]   r_nframes, w_nframes_nxt;
    logic [G_CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic [G_CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic [c_tmr_w-1:0]   r_timer, w_timer_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 r_pass, w_pass_nxt;
    logic                 r_tx_seen, w_tx_seen_nxt;
    logic                 r_tx_start, w_tx_start_nxt;
    logic                 r_rx_start, w_rx_start_nxt;
    logic                 r_done;
    logic                 r_busy;
    logic [G_CNT_W-1:0]   w_frame_inc;
    logic [G_CNT_W-1:0]   w_err_inc;
    logic                 w_abort;
    logic                 w_bad_frame;

    assign w_frame_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + G_CNT_W'(1);
    assign w_err_inc   = (&r_err_cnt)   ? r_err_cnt   : r_err_cnt + G_CNT_W'(1);
    assign w_abort     = test_stop && (r_state == S_ARM  || r_state == S_SEND ||
                                       r_state == S_WAIT || r_state == S_GAP);
    // A good EOF before the generator has even reported sending is spurious.
    assign w_bad_frame = rx_err || (rx_frame_ok && !r_tx_seen && !tx_done);

    always_comb begin
        w_state_nxt     = r_state;
        w_nframes_nxt   = r_nframes;
        w_frame_cnt_nxt = r_frame_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_timer_nxt     = r_timer;
        w_timeout_nxt   = r_timeout;
        w_pass_nxt      = r_pass;
        w_tx_seen_nxt   = r_tx_seen;
        w_tx_start_nxt  = 1'b0;
        w_rx_start_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (test_start && !test_stop) begin
                    w_nframes_nxt   = cfg_nframes;
                    w_frame_cnt_nxt = '0;
                    w_err_cnt_nxt   = '0;
                    w_timeout_nxt   = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_state_nxt     = S_ARM;
                end
            end
            S_ARM: begin
                w_rx_start_nxt = 1'b1;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                w_tx_start_nxt = 1'b1;
                w_timer_nxt    = c_tmo_load;
                w_tx_seen_nxt  = 1'b0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer - c_tmr_w'(1);
                if (tx_done) begin
                    w_tx_seen_nxt = 1'b1;
                end
                if (w_bad_frame) begin
                    w_err_cnt_nxt = w_err_inc;
                    w_timer_nxt   = c_gap_load;
                    w_state_nxt   = (G_STOP_ON_ERR != 0) ? S_FINISH : S_GAP;
                end else if (rx_frame_ok) begin
                    w_frame_cnt_nxt = w_frame_inc;
                    w_timer_nxt     = c_gap_load;
                    if (r_nframes != '0 && w_frame_inc == r_nframes) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else if (r_timer <= c_tmr_w'(1)) begin
                    w_timeout_nxt = 1'b1;
                    w_err_cnt_nxt = w_err_inc;
                    w_state_nxt   = S_FINISH;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_timer_nxt = r_timer - c_tmr_w'(1);
                end
            end
            S_FINISH: begin
                w_pass_nxt  = (r_err_cnt == '0) && !r_timeout;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Stop overrides the transition and any pulse, but WAIT counter updates stand.
        if (w_abort) begin
            w_state_nxt    = S_FINISH;
            w_tx_start_nxt = 1'b0;
            w_rx_start_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_nframes   <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_timer     <= '0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
            r_tx_seen   <= 1'b0;
            r_tx_start  <= 1'b0;
            r_rx_start  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nframes   <= w_nframes_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_timeout   <= w_timeout_nxt;
            r_pass      <= w_pass_nxt;
            r_tx_seen   <= w_tx_seen_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_rx_start  <= w_rx_start_nxt;
            r_done      <= (w_state_nxt == S_FINISH);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign tx_start  = r_tx_start;
    assign rx_start  = r_rx_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_seq_ctrl
// Brief    : Directed bench; instance 0 stops on error, instance 1 continues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] cfg_nframes = '0;
    logic         test_start = 1'b0;
    logic         test_stop  = 1'b0;

    logic         tx_start_o [2];
    logic         rx_start_o [2];
    logic         busy_o     [2];
    logic         done_o     [2];
    logic         pass_o     [2];
    logic         timeout_o  [2];
    logic [W-1:0] frame_cnt_o[2];
    logic [W-1:0] err_cnt_o  [2];
    logic         tx_done_i    [2];
    logic         rx_frame_ok_i[2];
    logic         rx_err_i     [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cd[2], txcnt[2], donecnt[2], okcnt[2], vcnt[2], last_tx[2], min_gap[2], tmo_cyc[2];
    int err_frame = 0;
    bit both_mode = 1'b0;
    bit withhold  = 1'b0;

    always #5 clk = ~clk;

    test_seq_ctrl #(.G_CNT_W(W), .G_TIMEOUT(4096), .G_GAP(12), .G_STOP_ON_ERR(1)) u_dut_stop (
        .clk(clk), .rst(rst), .cfg_nframes(cfg_nframes), .test_start(test_start),
        .test_stop(test_stop), .tx_start(tx_start_o[0]), .tx_done(tx_done_i[0]),
        .rx_start(rx_start_o[0]), .rx_frame_ok(rx_frame_ok_i[0]), .rx_err(rx_err_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .timeout(timeout_o[0]),
        .frame_cnt(frame_cnt_o[0]), .err_cnt(err_cnt_o[0])
    );

    test_seq_ctrl #(.G_CNT_W(W), .G_TIMEOUT(4096), .G_GAP(12), .G_STOP_ON_ERR(0)) u_dut_cont (
        .clk(clk), .rst(rst), .cfg_nframes(cfg_nframes), .test_start(test_start),
        .test_stop(test_stop), .tx_start(tx_start_o[1]), .tx_done(tx_done_i[1]),
        .rx_start(rx_start_o[1]), .rx_frame_ok(rx_frame_ok_i[1]), .rx_err(rx_err_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .timeout(timeout_o[1]),
        .frame_cnt(frame_cnt_o[1]), .err_cnt(err_cnt_o[1])
    );

    // Generator/checker model: tx_done 2 cycles after tx_start, verdict 4 cycles after.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            tx_done_i[i]     = 1'b0;
            rx_frame_ok_i[i] = 1'b0;
            if (!rst) begin
                cd[i] = 0; rx_err_i[i] = 1'b0; txcnt[i] = 0; donecnt[i] = 0; okcnt[i] = 0;
                vcnt[i] = 0; last_tx[i] = -1; min_gap[i] = 100000; tmo_cyc[i] = -1;
            end else begin
                if (rx_start_o[i]) rx_err_i[i] = 1'b0;
                if (done_o[i]) donecnt[i]++;
                if (timeout_o[i] && tmo_cyc[i] < 0) tmo_cyc[i] = cyc;
                if (tx_start_o[i]) begin
                    txcnt[i]++;
                    if (last_tx[i] >= 0 && cyc - last_tx[i] < min_gap[i]) min_gap[i] = cyc - last_tx[i];
                    last_tx[i] = cyc;
                    cd[i] = 1;
                end else if (cd[i] != 0) begin
                    cd[i]++;
                    if (cd[i] == 3) tx_done_i[i] = 1'b1;
                    if (cd[i] == 5) begin
                        cd[i] = 0;
                        if (!withhold) begin
                            vcnt[i]++;
                            if (txcnt[i] == err_frame) begin
                                rx_err_i[i] = 1'b1;
                                if (both_mode) rx_frame_ok_i[i] = 1'b1;
                            end else begin
                                rx_frame_ok_i[i] = 1'b1;
                                okcnt[i]++;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; test_start = 1'b0; test_stop = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic pulse_start(input logic [W-1:0] n);
        step();
        cfg_nframes = n; test_start = 1'b1;
        step();
        test_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy_o[i], done_o[i], pass_o[i], timeout_o[i], tx_start_o[i], rx_start_o[i],
                 frame_cnt_o[i], err_cnt_o[i]} !== '0)
                begin errors++; $display("FAIL reset_outputs[%0d]: got busy=%b cnt=%0d/%0d, expected all 0",
                                         i, busy_o[i], frame_cnt_o[i], err_cnt_o[i]); end
        end
        rst = 1'b1;
    endtask

    task automatic test_clean();
        int n;
        err_frame = 0; both_mode = 1'b0; withhold = 1'b0;
        do_reset();
        pulse_start(16'd3);
        checks++; if (rx_start_o[0] !== 1'b0) begin errors++; $display("FAIL latch_no_pulse: got %b expected 0", rx_start_o[0]); end
        step();
        checks++; if (rx_start_o[0] !== 1'b1) begin errors++; $display("FAIL rx_start_lat2: got %b expected 1", rx_start_o[0]); end
        step();
        checks++; if (tx_start_o[0] !== 1'b1) begin errors++; $display("FAIL tx_start_lat3: got %b expected 1", tx_start_o[0]); end
        n = 0;
        while (donecnt[0] == 0 && n < 400) begin step(); n++; end
        checks++; if (donecnt[0] == 0) begin errors++; $display("FAIL clean_done_wait: got no done, expected done within 400 cycles"); end
        checks++; if (pass_o[0] !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b expected 1", pass_o[0]); end
        checks++; if (frame_cnt_o[0] !== 16'd3) begin errors++; $display("FAIL clean_frame_cnt: got %0d expected 3", frame_cnt_o[0]); end
        checks++; if (err_cnt_o[0] !== 16'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt_o[0]); end
        checks++; if (timeout_o[0] !== 1'b0) begin errors++; $display("FAIL clean_timeout: got %b expected 0", timeout_o[0]); end
        checks++; if (txcnt[0] != 3) begin errors++; $display("FAIL clean_tx_pulses: got %0d expected 3", txcnt[0]); end
        // verdict at S+4, next rx_start 14 later, tx_start one after that
        checks++; if (min_gap[0] != 19) begin errors++; $display("FAIL clean_tx_spacing: got %0d expected 19", min_gap[0]); end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL clean_idle: got busy=%b expected 0", busy_o[0]); end
        for (int k = 0; k < 5; k++) step();
        checks++; if (donecnt[0] != 1) begin errors++; $display("FAIL clean_done_once: got %0d expected 1", donecnt[0]); end
    endtask

    task automatic test_rx_err();
        int n;
        err_frame = 2; both_mode = 1'b0; withhold = 1'b0;
        do_reset();
        pulse_start(16'd5);
        n = 0;
        while (donecnt[1] == 0 && n < 600) begin step(); n++; end
        checks++; if (donecnt[1] == 0) begin errors++; $display("FAIL err_done_wait: got no done, expected done within 600 cycles"); end
        step();
        checks++; if (txcnt[0] != 2) begin errors++; $display("FAIL err_stop_tx: got %0d expected 2", txcnt[0]); end
        checks++; if (frame_cnt_o[0] !== 16'd1) begin errors++; $display("FAIL err_stop_frames: got %0d expected 1", frame_cnt_o[0]); end
        checks++; if (err_cnt_o[0] !== 16'd1) begin errors++; $display("FAIL err_stop_errs: got %0d expected 1", err_cnt_o[0]); end
        checks++; if (pass_o[0] !== 1'b0) begin errors++; $display("FAIL err_stop_pass: got %b expected 0", pass_o[0]); end
        // run ends on the 5th good frame, which takes a 6th transmission
        checks++; if (txcnt[1] != 6) begin errors++; $display("FAIL err_cont_tx: got %0d expected 6", txcnt[1]); end
        checks++; if (frame_cnt_o[1] !== 16'd5) begin errors++; $display("FAIL err_cont_frames: got %0d expected 5", frame_cnt_o[1]); end
        checks++; if (err_cnt_o[1] !== 16'd1) begin errors++; $display("FAIL err_cont_errs: got %0d expected 1", err_cnt_o[1]); end
        checks++; if (pass_o[1] !== 1'b0) begin errors++; $display("FAIL err_cont_pass: got %b expected 0", pass_o[1]); end
    endtask

    task automatic test_timeout();
        int n;
        err_frame = 0; both_mode = 1'b0; withhold = 1'b1;
        do_reset();
        pulse_start(16'd1);
        n = 0;
        while (donecnt[0] == 0 && n < 4300) begin step(); n++; end
        checks++; if (donecnt[0] == 0) begin errors++; $display("FAIL tmo_done_wait: got no done, expected done within 4300 cycles"); end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (tmo_cyc[i] - last_tx[i] != 4096) begin errors++; $display("FAIL tmo_latency[%0d]: got %0d expected 4096", i, tmo_cyc[i] - last_tx[i]); end
            checks++; if (timeout_o[i] !== 1'b1) begin errors++; $display("FAIL tmo_flag[%0d]: got %b expected 1", i, timeout_o[i]); end
            checks++; if (err_cnt_o[i] !== 16'd1) begin errors++; $display("FAIL tmo_errs[%0d]: got %0d expected 1", i, err_cnt_o[i]); end
            checks++; if (pass_o[i] !== 1'b0) begin errors++; $display("FAIL tmo_pass[%0d]: got %b expected 0", i, pass_o[i]); end
        end
        withhold = 1'b0;
    endtask

    task automatic test_continuous_stop();
        int n;
        err_frame = 0; both_mode = 1'b0; withhold = 1'b0;
        do_reset();
        pulse_start(16'd0);
        n = 0;
        while (okcnt[0] < 3 && n < 300) begin step(); n++; end
        test_start = 1'b1; cfg_nframes = 16'd1;
        step();
        test_start = 1'b0;
        n = 0;
        while (okcnt[0] < 7 && n < 300) begin step(); n++; end
        checks++; if (okcnt[0] < 7) begin errors++; $display("FAIL cont_verdict_wait: got %0d verdicts expected 7", okcnt[0]); end
        test_stop = 1'b1;
        step();
        test_stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (done_o[i] !== 1'b1) begin errors++; $display("FAIL cont_stop_done[%0d]: got %b expected 1", i, done_o[i]); end
        end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (frame_cnt_o[i] !== 16'd7) begin errors++; $display("FAIL cont_frames[%0d]: got %0d expected 7", i, frame_cnt_o[i]); end
            checks++; if (pass_o[i] !== 1'b1) begin errors++; $display("FAIL cont_pass[%0d]: got %b expected 1", i, pass_o[i]); end
        end
        checks++; if (err_cnt_o[0] !== 16'd0) begin errors++; $display("FAIL cont_errs: got %0d expected 0", err_cnt_o[0]); end
    endtask

    task automatic test_both_and_reset();
        int n;
        err_frame = 1; both_mode = 1'b1; withhold = 1'b0;
        do_reset();
        pulse_start(16'd2);
        n = 0;
        while (vcnt[1] < 1 && n < 100) begin step(); n++; end
        for (int i = 0; i < 2; i++) begin
            checks++; if (err_cnt_o[i] !== 16'd1) begin errors++; $display("FAIL both_errs[%0d]: got %0d expected 1", i, err_cnt_o[i]); end
            checks++; if (frame_cnt_o[i] !== 16'd0) begin errors++; $display("FAIL both_frames[%0d]: got %0d expected 0", i, frame_cnt_o[i]); end
        end
        n = 0;
        while (txcnt[1] < 2 && n < 100) begin step(); n++; end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({busy_o[1], done_o[1], pass_o[1], timeout_o[1], tx_start_o[1], rx_start_o[1],
             frame_cnt_o[1], err_cnt_o[1]} !== '0)
            begin errors++; $display("FAIL wait_reset: got busy=%b errs=%0d, expected all 0", busy_o[1], err_cnt_o[1]); end
        rst = 1'b1;
        for (int k = 0; k < 40; k++) step();
        checks++; if (donecnt[1] != 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", donecnt[1]); end
        checks++; if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL reset_stays_idle: got %b expected 0", busy_o[1]); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_rx_err();
        test_timeout();
        test_continuous_stop();
        test_both_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
